// File: rtl/step_decoder.sv
// Purpose : decode a 4-phase stepper drive pattern into step pulses, direction,
//           position, speed class and a sticky sequencing-error flag.
// Latency : 1 cycle, all outputs registered; the edge that first samples a new q updates them.
// Backpressure: none; q is sampled every cycle and the block never stalls.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   asynchronous active-high reset
//   q          in   4-bit phase pattern from the stepper driver (synchronous to clk)
//   err_clr    in   synchronous clear of the sticky error flag
//   clockwise  out  direction of the last valid step (1 = clockwise)
//   moving     out  a valid step happened within the stop timeout
//   speed      out  00 stopped, 01 slow, 10 medium, 11 fast
//   position   out  signed-free step count, wraps modulo 2^POS_W
//   step_pulse out  one-cycle pulse per valid step
//   error      out  sticky illegal-pattern / skipped-phase flag
module step_decoder #(
  parameter int          POS_W  = 8,
  parameter int          PER_W  = 24,
  parameter int unsigned T_FAST = 2_500_000,
  parameter int unsigned T_MED  = 5_000_000,
  parameter int unsigned T_STOP = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       q,
  input  logic             err_clr,
  output logic             clockwise,
  output logic             moving,
  output logic [1:0]       speed,
  output logic [POS_W-1:0] position,
  output logic             step_pulse,
  output logic             error
);

  typedef enum logic {
    IDLE  = 1'b0,   // no phase latched (coils off, after reset or after an illegal pattern)
    TRACK = 1'b1    // legal one-hot phase latched in q_dly_q
  } state_t;

  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_SLOW = 2'b01;
  localparam logic [1:0] SPD_MED  = 2'b10;
  localparam logic [1:0] SPD_FAST = 2'b11;

  // Thresholds clamped to what the period counter can represent. With the default
  // PER_W the stop timeout is larger than the counter range, so the counter
  // saturating is itself treated as having reached the stop timeout.
  localparam logic [63:0] PER_MAX = (64'd1 << PER_W) - 64'd1;
  localparam logic [PER_W-1:0] FAST_LIM =
    PER_W'((64'(T_FAST) > PER_MAX) ? PER_MAX : 64'(T_FAST));
  localparam logic [PER_W-1:0] MED_LIM =
    PER_W'((64'(T_MED) > PER_MAX) ? PER_MAX : 64'(T_MED));
  localparam logic [PER_W-1:0] STOP_LIM =
    PER_W'((64'(T_STOP) > PER_MAX) ? PER_MAX : 64'(T_STOP));

  state_t             state_q, state_d;
  logic [3:0]         q_dly_q;            // q delayed by one cycle: the latched phase while tracking
  logic [PER_W-1:0]   per_q, per_d;       // cycles since the last valid step
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               cw_q, cw_d;
  logic               mov_q, mov_d;
  logic [1:0]         spd_q, spd_d;
  logic               stp_q, stp_d;
  logic               err_q, err_d;

  logic               q_onehot;
  logic               q_zero;
  logic [3:0]         cw_next;
  logic [3:0]         ccw_next;
  logic [3:0]         opp_phase;
  logic               step_cw;
  logic               step_ccw;
  logic               err_set;
  logic [PER_W-1:0]   per_inc;

  assign q_zero    = (q == 4'b0000);
  assign q_onehot  = (q == 4'b0001) || (q == 4'b0010) || (q == 4'b0100) || (q == 4'b1000);

  // Clockwise advances the active coil one bit to the left (1000 wraps to 0001).
  assign cw_next   = {q_dly_q[2:0], q_dly_q[3]};
  assign ccw_next  = {q_dly_q[0],   q_dly_q[3:1]};
  // Two positions away in either direction: a phase was skipped.
  assign opp_phase = {q_dly_q[1:0], q_dly_q[3:2]};

  assign per_inc   = (per_q == {PER_W{1'b1}}) ? per_q : per_q + 1'b1;

  // Phase decode: only a change of q relative to last cycle is an event, so a
  // pattern held steady (legal or not) never re-triggers anything.
  always_comb begin
    state_d  = state_q;
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    err_set  = 1'b0;

    if (q != q_dly_q) begin
      if (!q_zero && !q_onehot) begin
        err_set = 1'b1;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            // First legal phase only latches; there is no previous phase to compare.
            if (q_onehot) begin
              state_d = TRACK;
            end
          end
          TRACK: begin
            if (q_zero) begin
              state_d = IDLE;
            end else if (q == cw_next) begin
              step_cw = 1'b1;
            end else if (q == ccw_next) begin
              step_ccw = 1'b1;
            end else if (q == opp_phase) begin
              // Skipped phase: direction is ambiguous, so no step, but the new
              // phase becomes the reference for the next change.
              err_set = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Output / timing next-state.
  always_comb begin
    pos_d = pos_q;
    cw_d  = cw_q;
    mov_d = mov_q;
    spd_d = spd_q;
    stp_d = 1'b0;
    per_d = per_inc;
    // A new error in the same cycle as err_clr wins.
    err_d = err_set | (err_q & ~err_clr);

    if (step_cw || step_ccw) begin
      stp_d = 1'b1;
      cw_d  = step_cw;
      pos_d = step_cw ? pos_q + 1'b1 : pos_q - 1'b1;
      per_d = {{(PER_W-1){1'b0}}, 1'b1};
      mov_d = 1'b1;
      // Coming out of the stopped state the measured period is meaningless.
      if (!mov_q) begin
        spd_d = SPD_SLOW;
      end else if (per_q <= FAST_LIM) begin
        spd_d = SPD_FAST;
      end else if (per_q <= MED_LIM) begin
        spd_d = SPD_MED;
      end else begin
        spd_d = SPD_SLOW;
      end
    end else if (per_inc >= STOP_LIM) begin
      mov_d = 1'b0;
      spd_d = SPD_STOP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_dly_q <= 4'b0000;
      per_q   <= '0;
      pos_q   <= '0;
      cw_q    <= 1'b1;
      mov_q   <= 1'b0;
      spd_q   <= SPD_STOP;
      stp_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_dly_q <= q;
      per_q   <= per_d;
      pos_q   <= pos_d;
      cw_q    <= cw_d;
      mov_q   <= mov_d;
      spd_q   <= spd_d;
      stp_q   <= stp_d;
      err_q   <= err_d;
    end
  end

  assign clockwise  = cw_q;
  assign moving     = mov_q;
  assign speed      = spd_q;
  assign position   = pos_q;
  assign step_pulse = stp_q;
  assign error      = err_q;

endmodule

// File: doc/step_decoder.md
STEP_DECODER -- requirements
Module: step_decoder

Interface
REQ-001 Parameter POS_W, default 8: width of position counter.
REQ-002 Parameter PER_W, default 24: width of step-period counter.
REQ-003 Parameter T_FAST, default 2_500_000: max period (clk cycles) classed fast.
REQ-004 Parameter T_MED, default 5_000_000: max period classed medium.
REQ-005 Parameter T_STOP, default 25_000_000: cycles without a step before declaring stopped.
REQ-006 clk  in  1  single system clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 q  in  4  motor phase pattern from the stepper driver, synchronous to clk.
REQ-009 err_clr  in  1  synchronous clear of sticky error.
REQ-010 clockwise  out  1  direction of the last valid step (1 = clockwise).
REQ-011 moving  out  1  a valid step occurred within the last T_STOP cycles.
REQ-012 speed  out  2  speed class: 00 stopped, 01 slow, 10 medium, 11 fast.
REQ-013 position  out  POS_W  step count, +1 per clockwise step, -1 per counterclockwise step.
REQ-014 step_pulse  out  1  one-cycle pulse per valid step.
REQ-015 error  out  1  sticky illegal-pattern / skipped-phase flag.

Function
REQ-016 Clockwise sequence SHALL be 0001->0010->0100->1000->0001; counterclockwise is its reverse; 0000 = coils off.
REQ-017 Block SHALL register q into q_d each cycle; a change event is a cycle where q != q_d.
REQ-018 States SHALL be IDLE (no phase latched) and TRACK (phase latched in q_d, legal one-hot).
REQ-019 IDLE: q one-hot -> TRACK, no step, no position change; q = 0000 -> stay IDLE.
REQ-020 TRACK, q = next clockwise phase of q_d: step_pulse=1, position+1, clockwise=1.
REQ-021 TRACK, q = next counterclockwise phase of q_d: step_pulse=1, position-1, clockwise=0.
REQ-022 TRACK, q = 0000: -> IDLE, no step; moving/speed keep timing out normally.
REQ-023 TRACK, q one-hot but opposite phase of q_d (skipped phase): error=1, no step, position unchanged, stay TRACK.
REQ-024 Any q not one-hot and not 0000: error=1, no step, -> IDLE.
REQ-025 All outputs SHALL be registered; step_pulse/position/clockwise update on the edge that first samples the new q (visible one cycle after q changes).
REQ-026 Direction reversal SHALL take effect on the first reversed step; no extra latency.
REQ-027 Position SHALL wrap modulo 2^POS_W in both directions.
REQ-028 Period counter SHALL count clk cycles since last valid step, saturate at all-ones, and reset to 1 on each step.
REQ-029 On each step, with P = period counter value before reset: speed = 11 if P <= T_FAST, 10 if P <= T_MED, else 01.
REQ-030 First step after reset or after stopped SHALL give speed = 01 and moving=1.
REQ-031 When period counter reaches T_STOP: moving=0, speed=00; clockwise and position hold.
REQ-032 error SHALL stay set until err_clr or reset; err_clr and a new error in the same cycle -> error=1.

Reset
REQ-033 On reset assertion, immediately: state IDLE, q_d=0000, position=0, clockwise=1, moving=0, speed=00, step_pulse=0, error=0, period counter=0.
REQ-034 Reset mid-step SHALL discard any pending event; first one-hot q after release only latches phase.

Verification
REQ-035 Reset, q=0001, then 0010,0100,1000,0001 every 100 cycles (T_FAST=200) -> 4 step_pulses, position=4, clockwise=1, speed=11.
REQ-036 From position=4 tracking at 1000, apply 0100,0010 -> position=2, clockwise=0 after first reversed step, no error.
REQ-037 q=0001 then 0100 -> error=1, position unchanged; err_clr pulse -> error=0.
REQ-038 q=0011 -> error=1, state IDLE; next 0010 gives no step_pulse.
REQ-039 Steps stop for T_STOP cycles -> moving=0, speed=00, position held; position=0 with counterclockwise step -> position=2^POS_W-1.
REQ-040 Reset asserted asynchronously between clk edges mid-sequence -> all outputs at REQ-033 values before next edge.
